// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: start/stop + lap/clear control FSM, centisecond
// prescaler, BCD mm:ss.cc counter, lap capture and display mux.
module stopwatch_core #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned PRE_W    = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap_clear,
    output logic       running,
    output logic       lap_shown,
    output logic       overflow,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] cs_t,
    output logic [3:0] cs_u
);

    localparam int unsigned DIGITS = 6;
    localparam int unsigned CNT_W  = 4 * DIGITS;

    // Counter layout, LSB first: cs_u, cs_t, sec_u, sec_t, min_u, min_t.
    localparam logic [DIGITS-1:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
    localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE
    } state_t;

    state_t           state_q;
    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] lap_q;
    logic [CNT_W-1:0] disp;
    logic             counting;
    logic             tick;
    logic             wrap;
    logic             lc_acc;
    logic             go_idle;
    logic             lap_load;
    logic             carry;
    logic [3:0]       dig;

    // start_stop has priority: a coincident lap_clear is dropped.
    assign lc_acc   = lap_clear & ~start_stop;
    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (pre_q == PRE_LAST);
    assign go_idle  = (state_q == S_PAUSE) && lc_acc;
    assign lap_load = (state_q == S_RUN) && lc_acc;

    // Control FSM with registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            running   <= 1'b0;
            lap_shown <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_stop) begin
                        state_q <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        state_q <= S_PAUSE;
                        running <= 1'b0;
                    end else if (lc_acc) begin
                        state_q   <= S_LAP;
                        lap_shown <= 1'b1;
                    end
                end
                S_LAP: begin
                    if (start_stop) begin
                        state_q   <= S_PAUSE;
                        running   <= 1'b0;
                        lap_shown <= 1'b0;
                    end else if (lc_acc) begin
                        state_q   <= S_RUN;
                        lap_shown <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_q <= S_RUN;
                        running <= 1'b1;
                    end else if (lc_acc) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running   <= 1'b0;
                    lap_shown <= 1'b0;
                end
            endcase
        end
    end

    // Centisecond prescaler: advances while counting, held in PAUSE, zero in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else if (go_idle || (state_q == S_IDLE)) begin
            pre_q <= '0;
        end else if (counting) begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
        end
    end

    // BCD ripple increment of the whole counter on tick.
    always_comb begin
        cnt_nxt = cnt_q;
        carry   = tick;
        dig     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt_q[i*4 +: 4];
            if (carry) begin
                if (dig == DIG_MAX[i]) begin
                    dig   = 4'd0;
                    carry = 1'b1;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            cnt_nxt[i*4 +: 4] = dig;
        end
        wrap = carry;
    end

    // Live counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (go_idle) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    // Lap capture takes the post-edge count so a coincident tick is included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q <= '0;
        end else if (go_idle) begin
            lap_q <= '0;
        end else if (lap_load) begin
            lap_q <= cnt_nxt;
        end
    end

    // Sticky wrap flag, cleared only by a clear or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (go_idle) begin
            overflow <= 1'b0;
        end else if (wrap) begin
            overflow <= 1'b1;
        end
    end

    // Display source: frozen lap in LAP, live count otherwise.
    assign disp  = lap_shown ? lap_q : cnt_q;
    assign cs_u  = disp[3:0];
    assign cs_t  = disp[7:4];
    assign sec_u = disp[11:8];
    assign sec_t = disp[15:12];
    assign min_u = disp[19:16];
    assign min_t = disp[23:20];

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV=4.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       lap_clear;
    logic       running;
    logic       lap_shown;
    logic       overflow;
    logic [3:0] min_t, min_u, sec_t, sec_u, cs_t, cs_u;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_core #(
        .TICK_DIV (4),
        .PRE_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap_clear  (lap_clear),
        .running    (running),
        .lap_shown  (lap_shown),
        .overflow   (overflow),
        .min_t      (min_t),
        .min_u      (min_u),
        .sec_t      (sec_t),
        .sec_u      (sec_u),
        .cs_t       (cs_t),
        .cs_u       (cs_u)
    );

    always #5 clk = ~clk;

    // Compare display digits and {running, lap_shown, overflow}.
    task automatic chk(input string tag, input logic [23:0] exp_disp, input logic [2:0] exp_flags);
        logic [23:0] obs_disp;
        logic [2:0]  obs_flags;
        obs_disp  = {min_t, min_u, sec_t, sec_u, cs_t, cs_u};
        obs_flags = {running, lap_shown, overflow};
        n_cmp++;
        assert ({obs_disp, obs_flags} === {exp_disp, exp_flags}) else begin
            n_err++;
            $error("FAIL %s: observed disp=%h flags=%b, expected disp=%h flags=%b",
                   tag, obs_disp, obs_flags, exp_disp, exp_flags);
        end
    endtask

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic step(input logic ss, input logic lc);
        @(negedge clk);
        start_stop = ss;
        lap_clear  = lc;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_clear  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        start_stop = 1'b0;
        lap_clear  = 1'b0;
        #12;
        chk("reset_state", 24'h000000, 3'b000);

        // Start accepted on the very first edge with reset high.
        @(negedge clk);
        reset      = 1'b1;
        start_stop = 1'b1;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        chk("start", 24'h000000, 3'b100);
        idle(3);
        chk("pre_tick", 24'h000000, 3'b100);
        idle(1);
        chk("first_tick", 24'h000001, 3'b100);
        idle(396);
        chk("one_second", 24'h000100, 3'b100);
        step(1'b1, 1'b0);
        chk("pause1", 24'h000100, 3'b000);
        step(1'b0, 1'b1);
        chk("clear1", 24'h000000, 3'b000);
        step(1'b0, 1'b1);
        chk("idle_lap_clear", 24'h000000, 3'b000);

        // Pause/resume keeps the sub-tick fraction.
        step(1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b0);
        chk("pr_pause", 24'h000001, 3'b000);
        idle(20);
        chk("pr_frozen", 24'h000001, 3'b000);
        step(1'b1, 1'b0);
        chk("pr_resume", 24'h000001, 3'b100);
        idle(2);
        chk("pr_exact", 24'h000002, 3'b100);

        // Lap entered on a tick edge captures the incremented value.
        idle(191);
        step(1'b0, 1'b1);
        chk("lap_enter", 24'h000050, 3'b110);
        idle(40);
        chk("lap_frozen", 24'h000050, 3'b110);
        step(1'b0, 1'b1);
        chk("lap_exit", 24'h000060, 3'b100);

        // Coincident pulses: start_stop wins in every state.
        step(1'b1, 1'b1);
        chk("simul_run", 24'h000060, 3'b000);
        step(1'b1, 1'b1);
        chk("simul_pause", 24'h000060, 3'b100);
        step(1'b0, 1'b1);
        chk("lap2_enter", 24'h000060, 3'b110);
        step(1'b1, 1'b1);
        chk("simul_lap", 24'h000061, 3'b000);
        step(1'b0, 1'b1);
        chk("clear2", 24'h000000, 3'b000);

        // Run to 00:12.34, pause, clear.
        step(1'b1, 1'b0);
        idle(4935);
        step(1'b1, 1'b0);
        chk("pause_1234", 24'h001234, 3'b000);
        step(1'b0, 1'b1);
        chk("clear_1234", 24'h000000, 3'b000);

        // Preload 59:59.99 while paused, then let one tick wrap it.
        step(1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0);
        chk("pre_force", 24'h000000, 3'b000);
        @(negedge clk);
        force dut.cnt_q = 24'h595999;
        @(posedge clk);
        #1;
        chk("forced", 24'h595999, 3'b000);
        @(negedge clk);
        release dut.cnt_q;
        step(1'b1, 1'b0);
        chk("resume_max", 24'h595999, 3'b100);
        idle(1);
        chk("wrap", 24'h000000, 3'b101);
        idle(4);
        chk("post_wrap", 24'h000001, 3'b101);
        step(1'b1, 1'b0);
        chk("pause_ovf", 24'h000001, 3'b001);
        step(1'b0, 1'b1);
        chk("clear_ovf", 24'h000000, 3'b000);

        // Asynchronous reset while in LAP.
        step(1'b1, 1'b0);
        idle(9);
        step(1'b0, 1'b1);
        chk("lap3_enter", 24'h000002, 3'b110);
        idle(5);
        chk("lap3_frozen", 24'h000002, 3'b110);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 24'h000000, 3'b000);
        #10;
        chk("reset_hold", 24'h000000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch timekeeping and control block, directly downstream of the button press unit. Consumes the debounced, single-cycle button pulses for start/stop and lap/clear. Runs a control FSM over an internal 100 Hz prescaler and a BCD mm:ss.cc counter. Presents either the live time or a frozen lap time to the display driver.

## Interface
Parameters:
- TICK_DIV, default 500000: clk cycles per centisecond tick (50 MHz → 100 Hz); must be ≥2.
- PRE_W, default 19: prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_stop  input  1  one-cycle pulse from the button press unit (start/stop button).
- lap_clear  input  1  one-cycle pulse from the button press unit (lap/clear button).
- running  output  1  high in RUN and LAP.
- lap_shown  output  1  high in LAP.
- overflow  output  1  sticky flag; set on 59:59.99 → 00:00.00 wrap.
- min_t, min_u, sec_t, sec_u, cs_t, cs_u  output  4 each  displayed BCD digits.

## Operation
- FSM states: IDLE, RUN, LAP, PAUSE; encoding is free.
- IDLE: start_stop → RUN; lap_clear is ignored.
- RUN: start_stop → PAUSE; lap_clear → LAP and loads the lap registers.
- LAP: start_stop → PAUSE, and the display reverts to live; lap_clear → RUN, and the display reverts to live.
- PAUSE: start_stop → RUN; lap_clear → IDLE, which clears the count, prescaler, lap registers and overflow.
- Simultaneous start_stop and lap_clear in one cycle: start_stop wins and lap_clear is dropped, in every state.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP.
  - In those states, tick = 1 on the cycle it equals TICK_DIV-1; it then wraps to 0.
  - Holds its value in PAUSE, so the sub-tick fraction is preserved.
  - Is 0 in IDLE.
- Counter: BCD digits cs 00–99, sec 00–59, min 00–59, with ripple carry on tick.
  - Each digit unit rolls 9→0 and carries into its tens digit.
  - cs 99 carries into sec; sec 59 carries into min.
  - min 59 plus a carry wraps the whole counter to 00:00.00 and sets overflow.
  - The counter keeps running after the wrap.
- Lap registers are loaded with the counter's next-state value on the edge that accepts lap_clear in RUN, so a tick landing on that edge is included.
- Display outputs are the lap registers in LAP and the live counter otherwise (combinational mux from registers).
- Reset (asserted at any time, including mid-count or in LAP) forces IDLE, prescaler 0, counter 0, lap registers 0 and overflow 0.

## Timing
- Reset values: running=0, lap_shown=0, overflow=0, all digit outputs 0.
- Reset release: the first start_stop pulse is accepted on the first rising edge with reset high.
- Pulse acceptance: a pulse sampled high at edge N changes state at edge N; the new running/lap_shown levels are visible after edge N.
- Prescaler start: the first prescaler increment happens on edge N+1 after the RUN entry at edge N.
- First tick: cs_u becomes 1 after edge N+TICK_DIV when started from IDLE.
- Display latency: the digit outputs reflect a counter update in the same cycle after the updating edge, with zero extra latency.
- overflow rises after the wrapping edge. It is cleared only by the PAUSE→IDLE transition or by reset.
- Pause/resume: PAUSE then RUN resumes the prescaler from its held value, so accumulated RUN/LAP cycles are exact across pauses.
- Inputs are assumed to be one-cycle pulses. Held-high levels are treated as a pulse on every cycle; no edge detection is done inside this block.

## Test plan
(All scenarios use TICK_DIV=4.)
- Reset then start: release reset, pulse start_stop → running=1 next cycle; after 4 clks cs_u=1; after 400 clks the display reads 00:01.00.
- Pause/resume exactness:
  - Stimulus: start, run 6 clks, pause for 20 clks, resume, run 2 more clks.
  - Response: the display reads 00:00.02 and stays frozen during the pause.
- Lap freeze:
  - Stimulus: run to 00:00.50, pulse lap_clear, run 40 more clks.
  - Response: lap_shown=1 and the display stays at 00:00.50.
  - Then pulse lap_clear → the display reads 00:00.60.
- Clear:
  - Stimulus: from PAUSE at 00:12.34, pulse lap_clear.
  - Response: all digits 0, running=0, overflow=0.
  - A lap_clear in IDLE leaves the outputs unchanged.
- Simultaneous pulses: in RUN, pulse start_stop and lap_clear together → PAUSE, lap_shown=0, lap registers unchanged.
- Wrap and reset:
  - Stimulus: run to 59:59.99 (force or long sim), then one tick.
  - Response: 00:00.00 with overflow=1, and counting continues.
  - Then assert reset mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
